valid_way_ram: RTL and testbench

Parametrised, set-associative successor to the direct-mapped valid-bit array: it holds one valid bit per way per set, plus a per-set round-robin replacement pointer. It also provides a sequenced flush (invalidate-all) engine. The block sits beside the tag RAMs in the cache controller. A lookup returns all way-valid bits and a victim way one cycle later; the controller's fill and invalidate traffic uses a separate update port.

---
 rtl/valid_way_ram.sv | 116 +++++++++++
 tb/tb_valid_way_ram.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/valid_way_ram.sv
// Per-set way-valid bits with round-robin victim pointers and a one-set-per-cycle flush sweep.
// Lookup result is registered one cycle after acceptance; requests are dropped while sweeping.
module valid_way_ram #(
  parameter int SETS  = 32,
  parameter int WAYS  = 2,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Lookup,
  input  logic [IDX_W-1:0] Index,
  input  logic             UpdWrite,
  input  logic [IDX_W-1:0] UpdIndex,
  input  logic [WAY_W-1:0] UpdWay,
  input  logic             UpdValid,
  input  logic             FlushReq,
  output logic             Ready,
  output logic             RspValid,
  output logic [WAYS-1:0]  ValidOut,
  output logic [WAY_W-1:0] VictimWay,
  output logic             FlushBusy,
  output logic             FlushDone
);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_ptr   [SETS];
  logic             r_rsp_vld;
  logic [WAYS-1:0]  r_valid_out;
  logic [WAY_W-1:0] r_victim;
  logic             r_flush_done;

  logic [WAYS-1:0]  w_upd_valid;
  logic [WAY_W-1:0] w_upd_ptr;
  logic             w_bypass;
  logic [WAYS-1:0]  w_lk_valid;
  logic [WAY_W-1:0] w_lk_ptr;
  logic [WAY_W-1:0] w_victim;

  always_comb begin
    w_upd_valid = r_valid[UpdIndex];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == UpdWay) w_upd_valid[w] = UpdValid;
    end
    // Only a fill of the way the pointer already names advances it.
    w_upd_ptr = r_ptr[UpdIndex];
    if ((WAYS > 1) && UpdValid && (UpdWay == r_ptr[UpdIndex]))
      w_upd_ptr = r_ptr[UpdIndex] + 1'b1;

    w_bypass   = UpdWrite && (UpdIndex == Index);
    w_lk_valid = w_bypass ? w_upd_valid : r_valid[Index];
    w_lk_ptr   = w_bypass ? w_upd_ptr   : r_ptr[Index];

    w_victim = w_lk_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_lk_valid[w]) w_victim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rsp_vld    <= 1'b0;
      r_valid_out  <= '0;
      r_victim     <= '0;
      r_flush_done <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      r_rsp_vld    <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (UpdWrite) begin
            r_valid[UpdIndex] <= w_upd_valid;
            r_ptr[UpdIndex]   <= w_upd_ptr;
          end
          if (Lookup) begin
            r_rsp_vld   <= 1'b1;
            r_valid_out <= w_lk_valid;
            r_victim    <= w_victim;
          end
          if (FlushReq) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
          end
        end
        S_SWEEP: begin
          r_valid[r_cnt] <= '0;
          r_ptr[r_cnt]   <= '0;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(SETS - 1)) begin
            r_state      <= S_IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Ready     = (r_state == S_IDLE);
  assign FlushBusy = (r_state == S_SWEEP);
  assign RspValid  = r_rsp_vld;
  assign ValidOut  = r_valid_out;
  assign VictimWay = r_victim;
  assign FlushDone = r_flush_done;

endmodule

// File: tb/tb_valid_way_ram.sv
// Directed and random bench for valid_way_ram with a per-cycle reference model.
module tb_valid_way_ram;
  localparam int SETS  = 32;
  localparam int WAYS  = 2;
  localparam int IDX_W = 5;
  localparam int WAY_W = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             Reset, Lookup, UpdWrite, UpdValid, FlushReq;
  logic [IDX_W-1:0] Index, UpdIndex;
  logic [WAY_W-1:0] UpdWay;
  logic             Ready, RspValid, FlushBusy, FlushDone;
  logic [WAYS-1:0]  ValidOut;
  logic [WAY_W-1:0] VictimWay;

  valid_way_ram #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .Reset(Reset), .Lookup(Lookup), .Index(Index),
    .UpdWrite(UpdWrite), .UpdIndex(UpdIndex), .UpdWay(UpdWay), .UpdValid(UpdValid),
    .FlushReq(FlushReq), .Ready(Ready), .RspValid(RspValid), .ValidOut(ValidOut),
    .VictimWay(VictimWay), .FlushBusy(FlushBusy), .FlushDone(FlushDone)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: valid masks, pointers and a remaining-busy-cycles count.
  int m_valid [SETS];
  int m_ptr   [SETS];
  int busy_left = 0;
  int exp_rsp = 0, exp_done = 0, exp_vo = 0, exp_vw = 0;
  bit chk_en = 0;

  function automatic int vict(input int vm, input int p);
    for (int w = 0; w < WAYS; w++) if (vm[w] == 1'b0) return w;
    return p;
  endfunction

  always @(posedge clk) begin
    exp_rsp  = 0;
    exp_done = 0;
    if (Reset) begin
      for (int s = 0; s < SETS; s++) begin m_valid[s] = 0; m_ptr[s] = 0; end
      busy_left = 0; exp_vo = 0; exp_vw = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        exp_done = 1;
        for (int s = 0; s < SETS; s++) begin m_valid[s] = 0; m_ptr[s] = 0; end
      end
    end else begin
      if (UpdWrite) begin
        if (UpdValid) m_valid[UpdIndex] = m_valid[UpdIndex] | (1 << UpdWay);
        else          m_valid[UpdIndex] = m_valid[UpdIndex] & ~(1 << UpdWay);
        if (UpdValid && int'(UpdWay) == m_ptr[UpdIndex])
          m_ptr[UpdIndex] = (m_ptr[UpdIndex] + 1) % WAYS;
      end
      if (Lookup) begin
        exp_rsp = 1;
        exp_vo  = m_valid[Index];
        exp_vw  = vict(exp_vo, m_ptr[Index]);
      end
      if (FlushReq) busy_left = SETS;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ready", Ready, busy_left == 0);
      cmp("flush_busy", FlushBusy, busy_left > 0);
      cmp("flush_done", FlushDone, exp_done);
      cmp("rsp_valid", RspValid, exp_rsp);
      cmp("valid_out", ValidOut, exp_vo);
      cmp("victim_way", VictimWay, exp_vw);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int idx);
    Lookup = 1'b1; Index = IDX_W'(idx);
    step();
    Lookup = 1'b0;
  endtask

  task automatic upd(input int idx, input int way, input bit val);
    UpdWrite = 1'b1; UpdIndex = IDX_W'(idx); UpdWay = WAY_W'(way); UpdValid = val;
    step();
    UpdWrite = 1'b0;
  endtask

  task automatic lit_lookup(input string name, input int idx, input int vo, input int vw);
    lookup(idx);
    cmp({name, "_rsp"}, RspValid, 1);
    cmp({name, "_vo"}, ValidOut, vo);
    cmp({name, "_vw"}, VictimWay, vw);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    Reset = 1'b1; Lookup = 1'b0; UpdWrite = 1'b0; UpdValid = 1'b0; FlushReq = 1'b0;
    Index = '0; UpdIndex = '0; UpdWay = '0;
    step();
    Reset = 1'b0;
    chk_en = 1;
    cmp("rst_ready", Ready, 1);
    cmp("rst_rsp", RspValid, 0);
    cmp("rst_vo", ValidOut, 0);
    cmp("rst_vw", VictimWay, 0);
    cmp("rst_busy", FlushBusy, 0);
    cmp("rst_done", FlushDone, 0);

    lit_lookup("lk0", 0, 0, 0);
    lit_lookup("lk5", 5, 0, 0);
    lit_lookup("lk31", 31, 0, 0);

    upd(5, 0, 1'b1);
    upd(5, 1, 1'b1);
    lit_lookup("full5", 5, 2'b11, 0);
    upd(5, 0, 1'b1);
    lit_lookup("ptr5", 5, 2'b11, 1);

    // Update and lookup of the same set in one cycle.
    UpdWrite = 1'b1; UpdIndex = 7; UpdWay = 1; UpdValid = 1'b1;
    Lookup = 1'b1; Index = 7;
    step();
    UpdWrite = 1'b0; Lookup = 1'b0;
    cmp("byp_rsp", RspValid, 1);
    cmp("byp_vo", ValidOut, 2'b10);
    cmp("byp_vw", VictimWay, 0);
    upd(7, 1, 1'b0);
    lit_lookup("inv7", 7, 2'b00, 0);

    upd(1, 0, 1'b1); upd(2, 1, 1'b1); upd(3, 0, 1'b1); upd(3, 1, 1'b1);
    FlushReq = 1'b1;
    step();
    FlushReq = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (FlushBusy) begin
        busy_cnt++;
        cmp("sweep_no_ready", Ready, 0);
        cmp("sweep_no_rsp", RspValid, 0);
      end
      if (FlushDone) begin
        done_cnt++;
        cmp("done_ready", Ready, 1);
      end
      Lookup = FlushBusy; Index = 3; UpdWrite = FlushBusy; UpdIndex = 3; UpdWay = 0; UpdValid = 1'b1;
      step();
    end
    Lookup = 1'b0; UpdWrite = 1'b0;
    cmp("flush_busy_cycles", busy_cnt, SETS);
    cmp("flush_done_pulses", done_cnt, 1);
    for (int s = 0; s < SETS; s++) lit_lookup("post_flush", s, 0, 0);

    upd(4, 0, 1'b1); upd(6, 1, 1'b1);
    FlushReq = 1'b1;
    step();
    FlushReq = 1'b0;
    for (int i = 0; i < 10; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    cmp("abort_ready", Ready, 1);
    cmp("abort_busy", FlushBusy, 0);
    cmp("abort_done", FlushDone, 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (FlushDone) done_cnt++;
      step();
    end
    cmp("abort_no_done", done_cnt, 0);
    lit_lookup("abort4", 4, 0, 0);
    lit_lookup("abort6", 6, 0, 0);

    // A lookup followed by reset on the next edge loses its response.
    upd(8, 1, 1'b1);
    Lookup = 1'b1; Index = 8;
    step();
    cmp("sq_first_vo", ValidOut, 2'b10);
    Reset = 1'b1;
    step();
    Reset = 1'b0; Lookup = 1'b0;
    cmp("sq_rsp", RspValid, 0);
    cmp("sq_vo", ValidOut, 0);

    // Flush alongside an update and lookup of set 9.
    UpdWrite = 1'b1; UpdIndex = 9; UpdWay = 0; UpdValid = 1'b1;
    Lookup = 1'b1; Index = 9; FlushReq = 1'b1;
    step();
    UpdWrite = 1'b0; Lookup = 1'b0; FlushReq = 1'b0;
    cmp("fl_upd_rsp", RspValid, 1);
    cmp("fl_upd_vo", ValidOut, 2'b01);
    cmp("fl_upd_vw", VictimWay, 1);
    cmp("fl_upd_busy", FlushBusy, 1);
    for (int i = 0; i < 40 && !Ready; i++) step();
    cmp("fl_upd_ready", Ready, 1);
    lit_lookup("fl_upd9", 9, 0, 0);

    for (int i = 0; i < 600; i++) begin
      Lookup   = ($urandom_range(0, 1) == 1);
      Index    = IDX_W'($urandom_range(0, 7));
      UpdWrite = ($urandom_range(0, 2) != 0);
      UpdIndex = IDX_W'($urandom_range(0, 7));
      UpdWay   = WAY_W'($urandom_range(0, WAYS - 1));
      UpdValid = ($urandom_range(0, 3) != 0);
      FlushReq = ($urandom_range(0, 99) == 0);
      step();
    end
    Lookup = 1'b0; UpdWrite = 1'b0; FlushReq = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
